uart_cmd_parser: RTL and testbench

Command-frame parser sitting directly downstream of the UART receiver and upstream of its transmitter. It consumes received bytes, assembles fixed-length checksummed command frames and updates the signal-generator configuration registers (frequency tuning word, amplitude, waveform select, enable). Every completed frame is answered with a one-byte ACK or NAK through the UART transmit handshake.

---
 rtl/uart_cmd_parser.sv | 187 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Assembles 7-byte checksummed command frames from the UART
//            receiver (0xA5, CMD, P3, P2, P1, P0, CHK), updates the
//            signal-generator configuration registers and answers each
//            completed frame with ACK (0x06) or NAK (0x15) via the UART
//            transmit handshake.
// Ports    : ipClk, ipReset (sync, active-low)
//            ipRxData/ipRxValid         - receiver byte stream
//            opTxData/opTxSend/ipTxBusy - transmitter request handshake
//            opFreqWord, opAmplitude, opWaveSel, opEnable - config regs
//            opCfgUpdate - one-cycle pulse on a config write
//            opErrCount  - rejected frames (saturating)
//            opRxDrop    - sticky: byte arrived while a reply was pending
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 43400
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic [7:0]  ipRxData,
    input  logic        ipRxValid,
    output logic [7:0]  opTxData,
    output logic        opTxSend,
    input  logic        ipTxBusy,
    output logic [31:0] opFreqWord,
    output logic [15:0] opAmplitude,
    output logic [1:0]  opWaveSel,
    output logic        opEnable,
    output logic        opCfgUpdate,
    output logic [7:0]  opErrCount,
    output logic        opRxDrop
);

    localparam int            TW            = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]    SYNC_BYTE     = 8'hA5;
    localparam logic [7:0]    ACK_BYTE      = 8'h06;
    localparam logic [7:0]    NAK_BYTE      = 8'h15;

    typedef enum logic [2:0] {
        HUNT       = 3'd0,
        CMD        = 3'd1,
        PAYLOAD    = 3'd2,
        CHECK      = 3'd3,
        EXEC       = 3'd4,
        REPLY_REQ  = 3'd5,
        REPLY_WAIT = 3'd6
    } state_t;

    state_t        state;
    logic          rx_valid_q;
    logic [7:0]    cmd;
    logic [7:0]    chk;
    logic [31:0]   payload;
    logic [1:0]    idx;
    logic          chk_ok;
    logic [TW-1:0] tcount;
    logic          accept;
    logic          in_frame;
    logic          in_reply;

    // The receiver holds valid for a whole bit period; only its rising
    // edge counts as a new byte.
    assign accept   = ipRxValid & ~rx_valid_q;
    assign in_frame = (state == CMD) || (state == PAYLOAD) || (state == CHECK);
    assign in_reply = (state == EXEC) || (state == REPLY_REQ) || (state == REPLY_WAIT);

    always_ff @(posedge ipClk) begin
        if (!ipReset) begin
            state       <= HUNT;
            rx_valid_q  <= 1'b0;
            cmd         <= 8'h00;
            chk         <= 8'h00;
            payload     <= 32'h0;
            idx         <= 2'd0;
            chk_ok      <= 1'b0;
            tcount      <= '0;
            opTxData    <= 8'h00;
            opTxSend    <= 1'b0;
            opFreqWord  <= 32'h0;
            opAmplitude <= 16'h0;
            opWaveSel   <= 2'd0;
            opEnable    <= 1'b0;
            opCfgUpdate <= 1'b0;
            opErrCount  <= 8'h00;
            opRxDrop    <= 1'b0;
        end else begin
            rx_valid_q  <= ipRxValid;
            opCfgUpdate <= 1'b0;

            if (accept && in_reply) begin
                opRxDrop <= 1'b1;
            end

            // Inter-byte timeout: an accepted byte always wins over expiry.
            if (in_frame) begin
                if (accept) begin
                    tcount <= '0;
                end else if (tcount != TIMEOUT_LIMIT) begin
                    tcount <= tcount + 1'b1;
                end
            end else begin
                tcount <= '0;
            end

            case (state)
                HUNT: begin
                    if (accept && (ipRxData == SYNC_BYTE)) begin
                        state <= CMD;
                    end
                end

                CMD, PAYLOAD, CHECK: begin
                    if (accept) begin
                        if (state == CMD) begin
                            cmd   <= ipRxData;
                            chk   <= ipRxData;
                            idx   <= 2'd0;
                            state <= PAYLOAD;
                        end else if (state == PAYLOAD) begin
                            payload <= {payload[23:0], ipRxData};
                            chk     <= chk ^ ipRxData;
                            idx     <= idx + 2'd1;
                            if (idx == 2'd3) begin
                                state <= CHECK;
                            end
                        end else begin
                            chk_ok <= (ipRxData == chk);
                            state  <= EXEC;
                        end
                    end else if (tcount == TIMEOUT_LIMIT) begin
                        state <= HUNT;
                        if (opErrCount != 8'hFF) begin
                            opErrCount <= opErrCount + 8'd1;
                        end
                    end
                end

                EXEC: begin
                    if (chk_ok && (cmd >= 8'h01) && (cmd <= 8'h04)) begin
                        case (cmd[2:0])
                            3'd1:    opFreqWord  <= payload;
                            3'd2:    opAmplitude <= payload[15:0];
                            3'd3:    opWaveSel   <= payload[1:0];
                            default: opEnable    <= payload[0];
                        endcase
                        opCfgUpdate <= 1'b1;
                        opTxData    <= ACK_BYTE;
                    end else begin
                        opTxData <= NAK_BYTE;
                        if (opErrCount != 8'hFF) begin
                            opErrCount <= opErrCount + 8'd1;
                        end
                    end
                    opTxSend <= 1'b1;
                    state    <= REPLY_REQ;
                end

                REPLY_REQ: begin
                    // Transmitter only samples the request on baud ticks,
                    // so hold it until busy confirms it was taken.
                    if (ipTxBusy) begin
                        opTxSend <= 1'b0;
                        state    <= REPLY_WAIT;
                    end
                end

                REPLY_WAIT: begin
                    opTxSend <= 1'b0;
                    if (!ipTxBusy) begin
                        state <= HUNT;
                    end
                end

                default: begin
                    opTxSend <= 1'b0;
                    state    <= HUNT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_parser
// Purpose  : Directed self-checking bench for uart_cmd_parser. Drives framed
//            command bytes, models the transmitter busy handshake and checks
//            configuration registers, replies, error count and drop flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int TIMEOUT_CYCLES = 1000;

    logic        ipClk = 1'b0;
    logic        ipReset;
    logic [7:0]  ipRxData;
    logic        ipRxValid;
    logic [7:0]  opTxData;
    logic        opTxSend;
    logic        ipTxBusy;
    logic [31:0] opFreqWord;
    logic [15:0] opAmplitude;
    logic [1:0]  opWaveSel;
    logic        opEnable;
    logic        opCfgUpdate;
    logic [7:0]  opErrCount;
    logic        opRxDrop;

    int n_checks = 0;
    int n_fail   = 0;

    uart_cmd_parser #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .ipClk       (ipClk),
        .ipReset     (ipReset),
        .ipRxData    (ipRxData),
        .ipRxValid   (ipRxValid),
        .opTxData    (opTxData),
        .opTxSend    (opTxSend),
        .ipTxBusy    (ipTxBusy),
        .opFreqWord  (opFreqWord),
        .opAmplitude (opAmplitude),
        .opWaveSel   (opWaveSel),
        .opEnable    (opEnable),
        .opCfgUpdate (opCfgUpdate),
        .opErrCount  (opErrCount),
        .opRxDrop    (opRxDrop)
    );

    always #5 ipClk = ~ipClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic drive_byte(input logic [7:0] b, input int hold);
        ipRxData  = b;
        ipRxValid = 1'b1;
        repeat (hold) @(posedge ipClk);
        #1;
        ipRxValid = 1'b0;
        @(posedge ipClk);
        #1;
    endtask

    // Sends a full frame; the checksum byte is held one cycle so that the
    // return point is exactly two edges after its acceptance.
    task automatic run_frame(input logic [55:0] f, input int hold, input logic [7:0] exp_reply,
                             input logic exp_upd, input logic drop_in_wait, input string tag);
        for (int i = 0; i < 6; i++) begin
            drive_byte(f[55-8*i -: 8], hold);
        end
        drive_byte(f[7:0], 1);
        check({tag, " cfg_update N+2"}, {31'd0, opCfgUpdate}, {31'd0, exp_upd});
        check({tag, " tx_send N+2"}, {31'd0, opTxSend}, 32'd1);
        check({tag, " tx_data"}, {24'd0, opTxData}, {24'd0, exp_reply});
        @(posedge ipClk); #1;
        check({tag, " cfg_update N+3"}, {31'd0, opCfgUpdate}, 32'd0);
        repeat (5) @(posedge ipClk);
        #1;
        check({tag, " tx_send held"}, {31'd0, opTxSend}, 32'd1);
        check({tag, " tx_data held"}, {24'd0, opTxData}, {24'd0, exp_reply});
        ipTxBusy = 1'b1;
        @(posedge ipClk); #1;
        check({tag, " tx_send dropped"}, {31'd0, opTxSend}, 32'd0);
        if (drop_in_wait) begin
            drive_byte(8'hA5, 2);
            check({tag, " rx_drop"}, {31'd0, opRxDrop}, 32'd1);
        end
        repeat (3) @(posedge ipClk);
        #1;
        check({tag, " no resend while busy"}, {31'd0, opTxSend}, 32'd0);
        ipTxBusy = 1'b0;
        repeat (2) @(posedge ipClk);
        #1;
    endtask

    initial begin
        logic saw_send;
        ipReset   = 1'b0;
        ipRxData  = 8'h00;
        ipRxValid = 1'b0;
        ipTxBusy  = 1'b0;
        repeat (3) @(posedge ipClk);
        #1;
        check("reset freq", opFreqWord, 32'h0);
        check("reset tx_send", {31'd0, opTxSend}, 32'd0);
        check("reset err", {24'd0, opErrCount}, 32'd0);
        check("reset drop", {31'd0, opRxDrop}, 32'd0);
        ipReset = 1'b1;
        repeat (2) @(posedge ipClk);
        #1;

        // Configuration writes, all ACKed.
        run_frame(56'hA5_01_12_34_56_78_09, 3, 8'h06, 1'b1, 1'b0, "freq");
        check("freq value", opFreqWord, 32'h12345678);
        run_frame(56'hA5_02_00_00_0F_FF_F2, 3, 8'h06, 1'b1, 1'b0, "amp");
        check("amp value", {16'd0, opAmplitude}, 32'h0FFF);
        run_frame(56'hA5_03_00_00_00_02_01, 3, 8'h06, 1'b1, 1'b0, "wave");
        check("wave value", {30'd0, opWaveSel}, 32'd2);
        run_frame(56'hA5_04_00_00_00_01_05, 3, 8'h06, 1'b1, 1'b0, "enable");
        check("enable value", {31'd0, opEnable}, 32'd1);
        check("freq held", opFreqWord, 32'h12345678);
        check("err after acks", {24'd0, opErrCount}, 32'd0);

        // Rejected frames.
        run_frame(56'hA5_01_12_34_56_78_00, 3, 8'h15, 1'b0, 1'b0, "badchk");
        check("badchk freq unchanged", opFreqWord, 32'h12345678);
        check("badchk err", {24'd0, opErrCount}, 32'd1);
        run_frame(56'hA5_07_00_00_00_00_07, 3, 8'h15, 1'b0, 1'b0, "badcmd");
        check("badcmd err", {24'd0, opErrCount}, 32'd2);

        // Noise before sync is silently ignored.
        drive_byte(8'h3C, 3);
        drive_byte(8'h00, 3);
        repeat (3) @(posedge ipClk);
        #1;
        check("noise no send", {31'd0, opTxSend}, 32'd0);
        check("noise no err", {24'd0, opErrCount}, 32'd2);
        run_frame(56'hA5_02_00_00_12_34_24, 3, 8'h06, 1'b1, 1'b0, "after noise");
        check("after noise amp", {16'd0, opAmplitude}, 32'h1234);

        // Timeout after A5 01.
        drive_byte(8'hA5, 3);
        drive_byte(8'h01, 3);
        saw_send = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES - 10; i++) begin
            @(posedge ipClk); #1;
            if (opTxSend) saw_send = 1'b1;
        end
        check("timeout not early", {24'd0, opErrCount}, 32'd2);
        for (int i = 0; i < 30; i++) begin
            @(posedge ipClk); #1;
            if (opTxSend) saw_send = 1'b1;
        end
        check("timeout err", {24'd0, opErrCount}, 32'd3);
        check("timeout no reply", {31'd0, saw_send}, 32'd0);

        // Valid frame after timeout; a byte during REPLY_WAIT is dropped.
        check("drop clear before", {31'd0, opRxDrop}, 32'd0);
        run_frame(56'hA5_01_00_00_00_10_11, 3, 8'h06, 1'b1, 1'b1, "post timeout");
        check("post timeout freq", opFreqWord, 32'h00000010);
        run_frame(56'hA5_03_00_00_00_03_00, 3, 8'h06, 1'b1, 1'b0, "after drop");
        check("after drop wave", {30'd0, opWaveSel}, 32'd3);
        check("drop sticky", {31'd0, opRxDrop}, 32'd1);

        // Long receiver valid pulses: one acceptance per byte.
        run_frame(56'hA5_03_00_00_00_01_02, 434, 8'h06, 1'b1, 1'b0, "long valid");
        check("long valid wave", {30'd0, opWaveSel}, 32'd1);
        check("long valid err", {24'd0, opErrCount}, 32'd3);

        // Reset in the middle of a frame.
        drive_byte(8'hA5, 3);
        drive_byte(8'h01, 3);
        drive_byte(8'h12, 3);
        ipReset = 1'b0;
        @(posedge ipClk); #1;
        check("midreset freq", opFreqWord, 32'h0);
        check("midreset amp", {16'd0, opAmplitude}, 32'h0);
        check("midreset wave", {30'd0, opWaveSel}, 32'd0);
        check("midreset enable", {31'd0, opEnable}, 32'd0);
        check("midreset err", {24'd0, opErrCount}, 32'd0);
        check("midreset drop", {31'd0, opRxDrop}, 32'd0);
        check("midreset tx_data", {24'd0, opTxData}, 32'd0);
        ipReset = 1'b1;
        repeat (2) @(posedge ipClk);
        #1;
        run_frame(56'hA5_04_00_00_00_01_05, 3, 8'h06, 1'b1, 1'b0, "post reset");
        check("post reset enable", {31'd0, opEnable}, 32'd1);
        check("post reset freq", opFreqWord, 32'h0);
        check("post reset err", {24'd0, opErrCount}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
